mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multi-cycle CPU between two requesters.
  - Port 0: instruction fetch, read-only.
  - Port 1: load/store unit, read or write.
- Sits between the control-unit-driven datapath and the memory model.
- Serialises accesses, holds the memory address, data and strobes stable for a fixed memory latency, then returns read data with a one-cycle ack pulse.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 4, memory access latency in cycles (legal 1..15)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request, held until if_ack
if_addr  input  ADDR_W  fetch address
if_ack  output  1  one-cycle pulse: fetch complete, rdata valid
d_req  input  1  data request, held until d_ack
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_ack  output  1  one-cycle pulse: data access complete
rdata  output  DATA_W  registered read data, shared by both ports
busy  output  1  transaction in flight (state != IDLE)
owner  output  1  port of current or last transaction (0 = fetch, 1 = data)
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid in the last BUSY cycle

Behaviour:
- Reset: every output is 0; state = IDLE; counter = 0; RR pointer = 1.
- A reset asserted mid-transaction aborts it: no ack, strobes drop the next cycle.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Requests are sampled on the clock edge, and only in IDLE.
  - If any req is high: latch the winner's addr, we and wdata; set owner; load counter = MEM_LAT; go to BUSY.
- BUSY:
  - mem_addr and mem_wdata are driven from the latched values.
  - mem_read = ~we or mem_write = we, asserted for exactly MEM_LAT consecutive cycles.
  - The counter decrements each cycle.
  - At counter == 1: capture mem_rdata into rdata if it is a read; go to RESP.
- RESP:
  - Pulse if_ack or d_ack, according to owner, for exactly one cycle.
  - Strobes are 0; go to IDLE.
- Latency: req first sampled at edge t gives strobes in cycles t+1..t+MEM_LAT and ack in cycle t+MEM_LAT+1. Throughput is one access per MEM_LAT+2 cycles.
- Writes leave rdata unchanged. rdata holds its value until the next read completes.
- A requester must deassert req no later than its ack cycle. req still high in the following IDLE cycle counts as a new request.
- Dropping req before ack does not cancel the transaction; the ack still pulses.
- Requester inputs are ignored outside IDLE.
- Without the optional feature, simultaneous requests go to data (port 1) first.
- Counter width is 4 bits. MEM_LAT = 1 yields a single BUSY cycle.

Optional Feature:
- Macro: MEM_PORT_ARB_RR_EN.
- Defined:
  - Ties are broken round-robin. The port not equal to the pointer wins.
  - The pointer updates to the winner on every grant.
  - The reset pointer value 1 makes fetch win the first tie.
  - A lone requester always wins regardless of the pointer.
- Undefined: fixed data-first priority; no pointer register.

Decomposition:
- Shared package/header mem_arb_pkg:
  - State encodings: IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2.
  - Port ids: PORT_IF = 1'b0, PORT_D = 1'b1.
- Sub-module mem_arb_pick:
  - Combinational winner selection from if_req, d_req and the pointer.
  - Contains the MEM_PORT_ARB_RR_EN variants.
  - Keeps the FSM free of policy.

Test Plan:
- Lone fetch:
  - Stimulus: MEM_LAT = 4; if_req at t0 with addr 0x10; memory returns 0xDEADBEEF.
  - Response: mem_read high t1..t4, mem_addr = 0x10; if_ack at t5; rdata = 0xDEADBEEF; d_ack never.
- Store:
  - Stimulus: d_req with d_we = 1, addr 0x40, wdata 0x1234.
  - Response: mem_write high 4 cycles with mem_wdata = 0x1234; mem_read stays 0; d_ack after; rdata unchanged.
- Simultaneous requests, macro off:
  - Stimulus: if_req and d_req asserted together.
  - Response: data is served first with d_ack at t5; fetch granted at t6 with if_ack at t11.
- Simultaneous requests, MEM_PORT_ARB_RR_EN on:
  - Stimulus: three back-to-back ties.
  - Response: grant order is fetch, data, fetch.
- Reset mid-BUSY:
  - Stimulus: reset at t2 of a load.
  - Response: no ack; all outputs 0 the next cycle; a fresh if_req afterwards completes normally.
- MEM_LAT = 1:
  - Stimulus: a single load.
  - Response: exactly one strobe cycle and ack two cycles after the request edge.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encodings, port ids, counter sizing.
// Pure declarations; no logic, no latency, no backpressure.
// Imported by mem_arb_pick and mem_port_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int CNT_W = 4;

    // On a tie the port that did not win last time is served.
    function automatic logic tie_winner(input logic last_grant);
        return ~last_grant;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requests (MEM_PORT_ARB_RR_EN: round-robin ties).
// Zero latency: winner is a pure function of the requests and the round-robin pointer.
// No backpressure of its own; the FSM only consults it while idle.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
`ifdef MEM_PORT_ARB_RR_EN
    input  logic ptr,
`endif
    output logic any,
    output logic winner
);

    always_comb begin
        any    = if_req | d_req;
        winner = PORT_IF;
`ifdef MEM_PORT_ARB_RR_EN
        if (if_req && d_req) begin
            winner = tie_winner(ptr);
        end else if (d_req) begin
            winner = PORT_D;
        end
`else
        if (d_req) begin
            winner = PORT_D;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store accesses onto one memory port (MEM_PORT_ARB_RR_EN: round-robin ties).
// Latency: strobes MEM_LAT cycles after the grant edge, then a one-cycle ack; one access per MEM_LAT+2 cycles.
// Backpressure: requesters hold req until ack; requests are only sampled while idle.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              owner,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             req_any;
    logic             win;

`ifdef MEM_PORT_ARB_RR_EN
    logic rr_ptr;
`endif

    mem_arb_pick u_pick (
        .if_req (if_req),
        .d_req  (d_req),
`ifdef MEM_PORT_ARB_RR_EN
        .ptr    (rr_ptr),
`endif
        .any    (req_any),
        .winner (win)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= PORT_IF;
            rdata     <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MEM_PORT_ARB_RR_EN
            rr_ptr    <= 1'b1;
`endif
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        owner <= win;
                        cnt   <= LAT;
                        state <= BUSY;
                        if (win == PORT_D) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_read  <= ~d_we;
                            mem_write <= d_we;
                        end else begin
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_read  <= 1'b1;
                            mem_write <= 1'b0;
                        end
`ifdef MEM_PORT_ARB_RR_EN
                        rr_ptr <= win;
`endif
                    end
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    // Last strobe cycle: memory data is valid now, ack goes out next cycle.
                    if (cnt == CNT_W'(1)) begin
                        if (mem_read) begin
                            rdata <= mem_rdata;
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if_ack    <= (owner == PORT_IF);
                        d_ack     <= (owner == PORT_D);
                        state     <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus tie, early-drop, reset and MEM_LAT=1 sequences.
module tb_mem_port_arbiter;

    localparam int LAT = 4;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic        if_ack, d_ack, busy, owner, mem_read, mem_write;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic        l_if_req = 1'b0, l_d_req = 1'b0, l_d_we = 1'b0;
    logic [31:0] l_if_addr = '0, l_d_addr = '0, l_d_wdata = '0;
    logic        l_if_ack, l_d_ack, l_busy, l_owner, l_mem_read, l_mem_write;
    logic [31:0] l_rdata, l_mem_addr, l_mem_wdata, l_mem_rdata;

    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   ack_cnt = 0;
    txn_t sb[$];
    int   start_q[$];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {~a[15:0], a[15:0]};
    endfunction

    assign mem_rdata   = mem_val(mem_addr);
    assign l_mem_rdata = mem_val(l_mem_addr);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u0 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .busy(busy), .owner(owner),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
        .clk(clk), .reset(reset),
        .if_req(l_if_req), .if_addr(l_if_addr), .if_ack(l_if_ack),
        .d_req(l_d_req), .d_we(l_d_we), .d_addr(l_d_addr), .d_wdata(l_d_wdata), .d_ack(l_d_ack),
        .rdata(l_rdata), .busy(l_busy), .owner(l_owner),
        .mem_read(l_mem_read), .mem_write(l_mem_write), .mem_addr(l_mem_addr),
        .mem_wdata(l_mem_wdata), .mem_rdata(l_mem_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Transaction monitor: records the strobe window and scores each ack against the queue head.
    int          strb_cnt = 0;
    int          start_cyc = 0;
    bit          stable_err = 0;
    logic [31:0] s_addr, s_wdata;
    logic        s_we;
    always @(negedge clk) begin
        txn_t e;
        if (reset) begin
            strb_cnt   = 0;
            stable_err = 0;
        end else begin
            if (mem_read && mem_write) check("strobe_exclusive", 64'(1), 64'(0));
            if (mem_read || mem_write) begin
                if (strb_cnt == 0) begin
                    start_cyc = cyc;
                    s_addr    = mem_addr;
                    s_we      = mem_write;
                    s_wdata   = mem_wdata;
                end else if (mem_addr !== s_addr || mem_write !== s_we || mem_wdata !== s_wdata) begin
                    stable_err = 1;
                end
                strb_cnt++;
            end
            if (if_ack || d_ack) begin
                check("ack_exclusive", 64'(if_ack & d_ack), 64'(0));
                if (sb.size() == 0) begin
                    check("unexpected_ack", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("ack_port", 64'(d_ack), 64'(e.port));
                    check("owner", 64'(owner), 64'(e.port));
                    check("strobe_cycles", 64'(strb_cnt), 64'(LAT));
                    check("ack_latency", 64'(cyc - start_cyc), 64'(LAT));
                    check("mem_addr", 64'(s_addr), 64'(e.addr));
                    check("mem_write", 64'(s_we), 64'(e.we));
                    if (e.we) check("mem_wdata", 64'(s_wdata), 64'(e.wdata));
                    check("rdata", 64'(rdata), 64'(e.rdata));
                    check("strobe_stable", 64'(stable_err), 64'(0));
                end
                start_q.push_back(start_cyc);
                strb_cnt   = 0;
                stable_err = 0;
                ack_cnt++;
            end
        end
    end

    task automatic do_access(input logic p, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] exp_rd);
        int req_cyc;
        bit done;
        sb.push_back('{p, we, a, wd, exp_rd});
        @(negedge clk);
        req_cyc = cyc;
        if (p) begin
            d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            #1;
            if (if_ack || d_ack) done = 1;
        end
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        check("ack_seen", 64'(done), 64'(1));
        if (done) check("grant_edge", 64'(start_q[$]), 64'(req_cyc + 1));
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    initial begin
        vec_t vecs[6];
        logic model_ptr;
        logic w;
        int   n0, req_cyc, nstrb, first_c, ack_c;
        bit   l_if_seen;

        vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h40,  32'h1234,     32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 32'h44,  32'h0,        32'hFFBB0044};
        vecs[3] = '{1'b0, 1'b0, 32'h104, 32'h0,        32'hFEFB0104};
        vecs[4] = '{1'b1, 1'b1, 32'h200, 32'hA5A55A5A, 32'hFEFB0104};
        vecs[5] = '{1'b0, 1'b0, 32'h20,  32'h0,        32'hFFDF0020};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_owner", 64'(owner), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_strobes", 64'({mem_read, mem_write, if_ack, d_ack}), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));

        // MEM_LAT = 1 instance: one strobe cycle, ack two cycles after the request edge.
        @(negedge clk);
        req_cyc = cyc;
        l_d_req = 1'b1; l_d_addr = 32'h700;
        nstrb = 0; first_c = -1; ack_c = -1; l_if_seen = 0;
        for (int i = 0; i < 10 && ack_c < 0; i++) begin
            @(negedge clk);
            if (l_mem_read) begin
                if (first_c < 0) first_c = cyc;
                nstrb++;
            end
            if (l_if_ack) l_if_seen = 1;
            if (l_d_ack) begin
                ack_c = cyc;
                l_d_req = 1'b0;
            end
        end
        l_d_req = 1'b0;
        check("lat1_strobes", 64'(nstrb), 64'(1));
        check("lat1_first_strobe", 64'(first_c), 64'(req_cyc + 1));
        check("lat1_ack", 64'(ack_c), 64'(req_cyc + 2));
        check("lat1_rdata", 64'(l_rdata), 64'(32'hF8FF0700));
        check("lat1_no_if_ack", 64'(l_if_seen), 64'(0));

        for (int i = 0; i < 6; i++)
            do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

        // Fetch requester drops req early; the transaction still completes.
        sb.push_back('{1'b0, 1'b0, 32'h24, 32'h0, mem_val(32'h24)});
        @(negedge clk);
        n0 = ack_cnt;
        if_req = 1'b1; if_addr = 32'h24;
        @(negedge clk);
        if_req = 1'b0;
        for (int i = 0; i < 20 && ack_cnt == n0; i++) @(negedge clk);
        #1;
        check("early_drop_acked", 64'(ack_cnt - n0), 64'(1));

        // Fresh reset so the tie sequences start from the reset pointer.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Three back-to-back ties with both requests held throughout.
        model_ptr = 1'b1;
        for (int k = 0; k < 3; k++) begin
`ifdef MEM_PORT_ARB_RR_EN
            w = ~model_ptr;
`else
            w = 1'b1;
`endif
            model_ptr = w;
            if (w) sb.push_back('{1'b1, 1'b0, 32'h304, 32'h0, mem_val(32'h304)});
            else   sb.push_back('{1'b0, 1'b0, 32'h300, 32'h0, mem_val(32'h300)});
        end
        @(negedge clk);
        n0 = ack_cnt;
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h304;
        for (int i = 0; i < 60 && ack_cnt < n0 + 3; i++) begin
            @(negedge clk);
            #1;
        end
        if_req = 1'b0; d_req = 1'b0;
        check("tie3_acks", 64'(ack_cnt - n0), 64'(3));
        check("tie3_queue_empty", 64'(sb.size()), 64'(0));

        // One tie where each requester drops at its own ack: the loser follows with no gap.
`ifdef MEM_PORT_ARB_RR_EN
        w = ~model_ptr;
`else
        w = 1'b1;
`endif
        if (w) begin
            sb.push_back('{1'b1, 1'b0, 32'h304, 32'h0, mem_val(32'h304)});
            sb.push_back('{1'b0, 1'b0, 32'h300, 32'h0, mem_val(32'h300)});
        end else begin
            sb.push_back('{1'b0, 1'b0, 32'h300, 32'h0, mem_val(32'h300)});
            sb.push_back('{1'b1, 1'b0, 32'h304, 32'h0, mem_val(32'h304)});
        end
        @(negedge clk);
        n0 = ack_cnt;
        req_cyc = cyc;
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 60 && ack_cnt < n0 + 2; i++) begin
            @(negedge clk);
            #1;
            if (if_ack) if_req = 1'b0;
            if (d_ack) d_req = 1'b0;
        end
        if_req = 1'b0; d_req = 1'b0;
        check("tie2_acks", 64'(ack_cnt - n0), 64'(2));
        if (ack_cnt == n0 + 2) begin
            check("tie2_first_grant", 64'(start_q[$-1]), 64'(req_cyc + 1));
            check("tie2_throughput", 64'(start_q[$] - start_q[$-1]), 64'(LAT + 2));
        end

        // Reset in the middle of a load: no ack, everything clears, then a fetch runs normally.
        sb.delete();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        d_req = 1'b0;
        n0 = ack_cnt;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_strobes", 64'({mem_read, mem_write, if_ack, d_ack}), 64'(0));
        check("midrst_rdata", 64'(rdata), 64'(0));
        check("midrst_mem_addr", 64'(mem_addr), 64'(0));
        check("midrst_owner", 64'(owner), 64'(0));
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_no_ack", 64'(ack_cnt - n0), 64'(0));
        do_access(1'b0, 1'b0, 32'h600, 32'h0, 32'hF9FF0600);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, checks %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1, "timeout");
    end

endmodule
